// File: rtl/fast_pkg.sv
// fast_pkg: shared FSM state type and window geometry constants for the FAST window controller.
package fast_pkg;
    typedef enum logic {IDLE, ACTIVE} state_t;
    localparam int COORD_W_DEF = 10;
    localparam int WIN_SIZE    = 7;
    localparam int WIN_RADIUS  = 3;
endpackage

// File: rtl/fast_coord_delay.sv
// fast_coord_delay: fixed-depth delay of a valid flag and an (x,y) coordinate pair.
module fast_coord_delay #(
    parameter int DEPTH   = 2,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y
);
    logic [DEPTH-1:0]              v_sr;
    logic [DEPTH-1:0][COORD_W-1:0] x_sr, y_sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_sr <= '0;
            x_sr <= '0;
            y_sr <= '0;
        end else begin
            v_sr[0] <= in_valid;
            x_sr[0] <= in_x;
            y_sr[0] <= in_y;
            for (int i = 1; i < DEPTH; i++) begin
                v_sr[i] <= v_sr[i-1];
                x_sr[i] <= x_sr[i-1];
                y_sr[i] <= y_sr[i-1];
            end
        end
    end

    assign out_valid = v_sr[DEPTH-1];
    assign out_x     = x_sr[DEPTH-1];
    assign out_y     = y_sr[DEPTH-1];
endmodule

// File: rtl/fast_window_ctrl.sv
// fast_window_ctrl: pixel-stream framing, 7x7 window position tracking and
// candidate coordinate alignment for a FAST corner detector.
module fast_window_ctrl
    import fast_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COORD_W    = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    input  logic               pix_sof,
    input  logic               pix_eol,
    output logic               pix_ready,
    input  logic               feat_stall,
    input  logic               err_clr,
    output logic               lb_shift,
    output logic               window_valid,
    output logic [COORD_W-1:0] win_cx,
    output logic [COORD_W-1:0] win_cy,
    output logic               cand_valid,
    output logic [COORD_W-1:0] cand_x,
    output logic [COORD_W-1:0] cand_y,
    output logic               frame_done,
    output logic               err_sof,
    output logic               err_eol
);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);
    localparam logic [COORD_W-1:0] WIN_EDGE = COORD_W'(WIN_SIZE - 1);
    localparam logic [COORD_W-1:0] RAD      = COORD_W'(WIN_RADIUS);

    state_t             state, state_nxt;
    logic [COORD_W-1:0] col, row, cur_col, cur_row, col_nxt, row_nxt;
    logic               accept, count, row_end, last_pix, win_hit, set_sof, set_eol;

    always_comb begin
        pix_ready = !feat_stall;
        accept    = pix_valid && pix_ready;
        // a sof pixel always restarts at (0,0), from IDLE or mid-frame
        count     = accept && (state == ACTIVE || pix_sof);
        lb_shift  = count;
        cur_col   = pix_sof ? '0 : col;
        cur_row   = pix_sof ? '0 : row;
        row_end   = pix_eol || cur_col == LAST_COL;
        last_pix  = cur_col == LAST_COL && cur_row == LAST_ROW;
        win_hit   = count && cur_col >= WIN_EDGE && cur_row >= WIN_EDGE;
        set_sof   = accept && pix_sof && state == ACTIVE;
        set_eol   = count && (pix_eol != (cur_col == LAST_COL));
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        if (count) begin
            state_nxt = last_pix ? IDLE : ACTIVE;
            col_nxt   = row_end ? '0 : cur_col + COORD_W'(1);
            row_nxt   = last_pix ? '0 : row_end ? cur_row + COORD_W'(1) : cur_row;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            window_valid <= 1'b0;
            win_cx       <= '0;
            win_cy       <= '0;
            frame_done   <= 1'b0;
            err_sof      <= 1'b0;
            err_eol      <= 1'b0;
        end else begin
            state        <= state_nxt;
            col          <= col_nxt;
            row          <= row_nxt;
            window_valid <= win_hit;
            if (win_hit) begin
                win_cx <= cur_col - RAD;
                win_cy <= cur_row - RAD;
            end
            frame_done   <= count && last_pix;
            err_sof      <= set_sof || (err_sof && !err_clr);
            err_eol      <= set_eol || (err_eol && !err_clr);
        end
    end

    fast_coord_delay #(
        .DEPTH  (2),
        .COORD_W(COORD_W)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (window_valid),
        .in_x     (win_cx),
        .in_y     (win_cy),
        .out_valid(cand_valid),
        .out_x    (cand_x),
        .out_y    (cand_y)
    );
endmodule

// File: tb/tb_fast_window_ctrl.sv
// tb_fast_window_ctrl: directed test of fast_window_ctrl on an 8x8 image.
module tb_fast_window_ctrl;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = 10;

    logic clk = 0, rst_n = 0, pix_valid = 0, pix_sof = 0, pix_eol = 0, feat_stall = 0, err_clr = 0;
    logic pix_ready, lb_shift, window_valid, cand_valid, frame_done, err_sof, err_eol;
    logic [CW-1:0] win_cx, win_cy, cand_x, cand_y;

    int total = 0, bad = 0, n_shift = 0, n_done = 0;
    bit rnd_stall = 0;
    logic h_v[2];
    logic [CW-1:0] h_x[2], h_y[2];
    int wq_x[$], wq_y[$];

    always #5 clk = ~clk;

    fast_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix_ready(pix_ready), .feat_stall(feat_stall), .err_clr(err_clr), .lb_shift(lb_shift),
        .window_valid(window_valid), .win_cx(win_cx), .win_cy(win_cy), .cand_valid(cand_valid),
        .cand_x(cand_x), .cand_y(cand_y), .frame_done(frame_done), .err_sof(err_sof), .err_eol(err_eol)
    );

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // every rising edge passes through here so the 2-cycle history stays aligned
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            h_v = '{1'b0, 1'b0};
            h_x = '{'0, '0};
            h_y = '{'0, '0};
        end else begin
            chk("cand_valid", cand_valid, h_v[1]);
            chk("cand_x", cand_x, h_x[1]);
            chk("cand_y", cand_y, h_y[1]);
            h_v[1] = h_v[0]; h_x[1] = h_x[0]; h_y[1] = h_y[0];
            h_v[0] = window_valid; h_x[0] = win_cx; h_y[0] = win_cy;
            if (window_valid) begin
                wq_x.push_back(int'(win_cx));
                wq_y.push_back(int'(win_cy));
            end
            if (frame_done) n_done++;
        end
    endtask

    task automatic px(input logic sof, input logic eol);
        bit done = 0;
        do begin
            @(negedge clk);
            pix_valid  = 1;
            pix_sof    = sof;
            pix_eol    = eol;
            feat_stall = rnd_stall && ($urandom_range(0, 2) == 0);
            #1;
            chk("pix_ready", pix_ready, !feat_stall);
            if (lb_shift) n_shift++;
            done = !feat_stall;
            tick();
            if (!done) chk("stall_wv", window_valid, 0);
        end while (!done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pix_valid = 0; pix_sof = 0; pix_eol = 0; feat_stall = 0;
            tick();
        end
    endtask

    task automatic pixels(input int r0, input int c0, input int r1, input int c1, input bit sof);
        for (int r = r0; r <= r1; r++)
            for (int c = (r == r0) ? c0 : 0; c <= ((r == r1) ? c1 : W - 1); c++)
                px(sof && r == r0 && c == c0, c == W - 1);
    endtask

    task automatic begin_frame();
        wq_x.delete(); wq_y.delete();
        n_done = 0; n_shift = 0;
    endtask

    task automatic check_windows(input string tag);
        int ex[4] = '{3, 4, 3, 4};
        int ey[4] = '{3, 3, 4, 4};
        chk({tag, "_nwin"}, wq_x.size(), 4);
        if (wq_x.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_cx"}, wq_x[i], ex[i]);
                chk({tag, "_cy"}, wq_y[i], ey[i]);
            end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        pix_valid = 0; err_clr = 1;
        tick();
        err_clr = 0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_wv", window_valid, 0);
        chk("rst_cand_v", cand_valid, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err_sof", err_sof, 0);
        chk("rst_err_eol", err_eol, 0);
        chk("rst_cx", win_cx, 0);
        chk("rst_cy", win_cy, 0);
        chk("rst_cand_x", cand_x, 0);
        chk("rst_cand_y", cand_y, 0);
        chk("rst_ready", pix_ready, 1);
        rst_n = 1;
        idle(2);

        // clean frame
        begin_frame();
        pixels(0, 0, 7, 7, 1);
        idle(3);
        check_windows("clean");
        chk("clean_done", n_done, 1);
        chk("clean_shift", n_shift, 64);
        chk("clean_err_sof", err_sof, 0);
        chk("clean_err_eol", err_eol, 0);
        n_shift = 0;
        px(0, 0); px(0, 1);
        idle(2);
        chk("idle_drop_shift", n_shift, 0);
        chk("idle_drop_err", err_eol, 0);

        // random backpressure
        begin_frame();
        rnd_stall = 1;
        pixels(0, 0, 7, 7, 1);
        rnd_stall = 0;
        idle(3);
        check_windows("stall");
        chk("stall_done", n_done, 1);
        chk("stall_shift", n_shift, 64);
        chk("stall_err_eol", err_eol, 0);

        // early eol at (5,2)
        begin_frame();
        pixels(0, 0, 1, 7, 1);
        pixels(2, 0, 2, 4, 0);
        px(0, 1);
        chk("eol_err_set", err_eol, 1);
        pixels(3, 0, 7, 7, 0);
        idle(2);
        check_windows("eol");
        chk("eol_done", n_done, 1);
        chk("eol_sticky", err_eol, 1);
        chk("eol_err_sof", err_sof, 0);
        pulse_clear();
        chk("eol_cleared", err_eol, 0);

        // sof at (4,5) mid-frame
        begin_frame();
        pixels(0, 0, 4, 7, 1);
        pixels(5, 0, 5, 3, 0);
        px(1, 0);
        chk("sof_err_set", err_sof, 1);
        chk("sof_no_done", n_done, 0);
        pixels(0, 1, 7, 7, 0);
        idle(2);
        check_windows("sof");
        chk("sof_done", n_done, 1);
        chk("sof_shift", n_shift, 108);
        pulse_clear();
        chk("sof_cleared", err_sof, 0);

        // col==W-1 without eol, with simultaneous clear
        begin_frame();
        pixels(0, 0, 0, 6, 1);
        err_clr = 1;
        px(0, 0);
        err_clr = 0;
        chk("noeol_set_wins", err_eol, 1);
        pixels(1, 0, 7, 7, 0);
        idle(2);
        check_windows("noeol");
        chk("noeol_done", n_done, 1);
        pulse_clear();
        chk("noeol_cleared", err_eol, 0);

        // reset during row 6
        begin_frame();
        pixels(0, 0, 5, 7, 1);
        pixels(6, 0, 6, 6, 0);
        px(0, 0);
        chk("pre_rst_nwin", wq_x.size(), 2);
        chk("pre_rst_err", err_eol, 1);
        @(negedge clk);
        rst_n = 0; pix_valid = 0;
        tick();
        chk("mid_rst_wv", window_valid, 0);
        chk("mid_rst_cand_v", cand_valid, 0);
        chk("mid_rst_err_eol", err_eol, 0);
        chk("mid_rst_cx", win_cx, 0);
        chk("mid_rst_cy", win_cy, 0);
        chk("mid_rst_cand_x", cand_x, 0);
        rst_n = 1;
        n_shift = 0;
        px(0, 0); px(0, 0); px(0, 1);
        pixels(7, 1, 7, 7, 0);
        idle(3);
        chk("post_rst_shift", n_shift, 0);
        chk("post_rst_no_done", n_done, 0);
        begin_frame();
        pixels(0, 0, 7, 7, 1);
        idle(3);
        check_windows("after_rst");
        chk("after_rst_done", n_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
